serving_counter: RTL and testbench
==================================

# serving_counter

Two-slot serving window feeding `orders_and_points`. It accepts dish placements from two players, holds each dish on `check_spaces` until `orders_and_points` claims it via `clear_space0`/`clear_space1`, and discards unclaimed dishes after a frame timeout. Outputs also drive the counter sprites and a discard statistic.

## Interface
- `PRESENT_FRAMES`, default 30: frames an unclaimed dish stays presented before it is discarded.
- `DISCARD_FRAMES`, default 15: frames a slot stays busy in the discard animation.

- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `vsync`  in  1  frame signal; each rising edge is one frame tick.
- `timer_go`  in  1  game running.
- `place_req`  in  [1:0]  per-player placement request, one-cycle pulse.
- `place_slot`  in  [1:0]  per-player target slot (0/1).
- `place_dish`  in  [1:0][3:0]  per-player dish code; 0 = none.
- `clear_space0`, `clear_space1`  in  1 each  claim pulses from `orders_and_points`.
- `check_spaces`  out  [1:0][3:0]  presented dish per slot; 0 when not presenting.
- `place_ack`, `place_nack`  out  [1:0] each  per-player one-cycle response.
- `slot_state`  out  [1:0][1:0]  per-slot state for graphics: 0 EMPTY, 1 PRESENT, 2 DISCARD.
- `discard_count`  out  8  saturating count of discarded dishes.

## Operation
- Frame tick: `vsync & ~vsync_q`. `vsync_q` resets to 0.
- Per-slot FSM:
  - EMPTY → PRESENT on an accepted placement. Latch the code and zero the frame counter.
  - PRESENT → EMPTY on the slot's clear pulse.
  - PRESENT → DISCARD when a tick with `timer_go`=1 brings the frame counter to `PRESENT_FRAMES`. `discard_count` increments, saturating at 255.
  - DISCARD → EMPTY when a tick brings the counter to `DISCARD_FRAMES`. The counter is zeroed on entry.
  - Clear pulses in EMPTY or DISCARD are ignored.
- Acceptance requires all of: `timer_go`=1, target slot EMPTY in the sampling cycle, and `place_dish`≠0. Any request that fails is nacked.
- Arbitration: if both players target the same EMPTY slot, player 0 is acked and player 1 is nacked. Requests to different slots can both be acked.
- `timer_go`=0:
  - every request is nacked;
  - PRESENT and DISCARD frame counters freeze;
  - clear pulses are still honoured.
- Simultaneous clear and timeout tick in PRESENT: clear wins; no discard and no count.
- A placement to a slot that is being cleared in the same cycle is nacked, because the slot is not yet EMPTY.
- Counter width: `$clog2(max(PRESENT_FRAMES,DISCARD_FRAMES)+1)`.

## Timing
- All outputs are registered.
- Reset values:
  - `check_spaces`=0
  - `place_ack`=`place_nack`=0
  - `slot_state`=EMPTY
  - `discard_count`=0
  - all frame counters 0
- Placement request sampled at cycle t. At t+1:
  - `place_ack` or `place_nack` pulses for exactly one cycle;
  - on ack, `slot_state`=PRESENT and `check_spaces[n]`=dish.
- Clear sampled at t → at t+1, `check_spaces[n]`=0 and `slot_state`=EMPTY.
- The tick that hits a limit changes state at the next clock edge.
- `check_spaces[n]` is nonzero only in PRESENT.
- Asserting reset mid-operation clears everything immediately. A dish in flight is lost and is not counted as discarded.

## Structure
- `serving_pkg` holds:
  - `slot_state_t` enum (EMPTY, PRESENT, DISCARD);
  - `DISH_NONE`=4'd0;
  - `NUM_SLOTS`=2.
- Sub-module `serving_slot`, instantiated twice, contains the FSM, frame counter and latched code. Its inputs are `accept`, `dish`, `clear`, `tick`, `run`. Its outputs are `state`, `code` and a `discard` pulse.
- The top level contains the vsync edge detector, the arbitration/ack logic and the saturating `discard_count`.

## Test plan
All scenarios use `PRESENT_FRAMES`=4 and `DISCARD_FRAMES`=2.

1. Player 0 places dish 4 in slot 0, then `clear_space0` is pulsed 3 cycles later.
   - Ack at t+1, `check_spaces[0]`=4.
   - One cycle after the clear: `check_spaces[0]`=0, slot EMPTY, `discard_count`=0.
2. Dish 5 is placed in slot 1 and never cleared.
   - After 4 ticks: DISCARD, `check_spaces[1]`=0, `discard_count`=1.
   - After 2 more ticks: EMPTY.
3. Both players request slot 0 in the same cycle with dishes 2 and 3.
   - `place_ack`=2'b01, `place_nack`=2'b10, `check_spaces[0]`=2.
4. Requests with `timer_go`=0 are nacked. With a dish already presented, dropping `timer_go` for 10 ticks causes no discard; raising it again, the dish discards after its remaining ticks.
5. `clear_space0` and the 4th tick land in the same cycle.
   - Slot goes EMPTY and `discard_count` is unchanged.
6. Reset is asserted while slot 0 is PRESENT with dish 7.
   - All outputs go to their reset values asynchronously, and `discard_count` stays 0.
   - A placement of dish 0 is nacked.

Source files
------------

// File: rtl/serving_pkg.sv
// Shared types and constants for the two-slot serving counter.
package serving_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PRESENT = 2'd1,
        DISCARD = 2'd2
    } slot_state_t;

    localparam logic [3:0] DISH_NONE = 4'd0;
    localparam int         NUM_SLOTS = 2;

endpackage

// File: rtl/serving_slot.sv
// One serving slot: holds a dish while presented, times it out into a discard
// animation, and returns to empty when claimed or when the animation ends.
module serving_slot
    import serving_pkg::*;
#(
    parameter int PRESENT_FRAMES = 30,
    parameter int DISCARD_FRAMES = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       accept,
    input  logic [3:0] dish,
    input  logic       clear,
    input  logic       tick,
    input  logic       run,
    output logic [1:0] state,
    output logic [3:0] code,
    output logic       discard
);

    localparam int MAX_FRAMES = (PRESENT_FRAMES > DISCARD_FRAMES) ? PRESENT_FRAMES : DISCARD_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    slot_state_t      state_q, state_d;
    logic [3:0]       code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             frame;

    assign cnt_inc = cnt_q + 1'b1;
    // Frame counters only advance while the game is running.
    assign frame   = tick & run;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        discard = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = PRESENT;
                    code_d  = dish;
                    cnt_d   = '0;
                end
            end
            PRESENT: begin
                // A claim outranks a timeout landing in the same cycle.
                if (clear) begin
                    state_d = EMPTY;
                    code_d  = DISH_NONE;
                end else if (frame) begin
                    if (cnt_inc == CNT_W'(PRESENT_FRAMES)) begin
                        state_d = DISCARD;
                        code_d  = DISH_NONE;
                        cnt_d   = '0;
                        discard = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            DISCARD: begin
                if (frame) begin
                    if (cnt_inc == CNT_W'(DISCARD_FRAMES)) begin
                        state_d = EMPTY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
                code_d  = DISH_NONE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            code_q  <= DISH_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;
    assign code  = code_q;

endmodule

// File: rtl/serving_counter.sv
// Two-slot serving window: arbitrates player placements, presents dishes to the
// order logic and keeps a saturating tally of dishes that timed out.
module serving_counter
    import serving_pkg::*;
#(
    parameter int PRESENT_FRAMES = 30,
    parameter int DISCARD_FRAMES = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            vsync,
    input  logic            timer_go,
    input  logic [1:0]      place_req,
    input  logic [1:0]      place_slot,
    input  logic [1:0][3:0] place_dish,
    input  logic            clear_space0,
    input  logic            clear_space1,
    output logic [1:0][3:0] check_spaces,
    output logic [1:0]      place_ack,
    output logic [1:0]      place_nack,
    output logic [1:0][1:0] slot_state,
    output logic [7:0]      discard_count
);

    logic                 vsync_q;
    logic                 tick;
    logic [1:0]           ok;
    logic [1:0]           place_ack_d, place_ack_q;
    logic [1:0]           place_nack_d, place_nack_q;
    logic [7:0]           discard_count_d, discard_count_q;
    logic [8:0]           discard_sum;
    logic [NUM_SLOTS-1:0] accept;
    logic [NUM_SLOTS-1:0] clear;
    logic [NUM_SLOTS-1:0] discard;
    logic [3:0]           dish_sel [NUM_SLOTS];
    logic [1:0]           st       [NUM_SLOTS];

    assign tick  = vsync & ~vsync_q;
    assign clear = {clear_space1, clear_space0};

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            ok[p] = place_req[p] & timer_go & (st[place_slot[p]] == EMPTY)
                  & (place_dish[p] != DISH_NONE);
        end
        // Player 0 wins a contested slot.
        place_ack_d[0] = ok[0];
        place_ack_d[1] = ok[1] & ~(ok[0] & (place_slot[0] == place_slot[1]));
        place_nack_d   = place_req & ~place_ack_d;

        for (int s = 0; s < NUM_SLOTS; s++) begin
            accept[s]   = 1'b0;
            dish_sel[s] = DISH_NONE;
            if (place_ack_d[0] && (32'(place_slot[0]) == s)) begin
                accept[s]   = 1'b1;
                dish_sel[s] = place_dish[0];
            end else if (place_ack_d[1] && (32'(place_slot[1]) == s)) begin
                accept[s]   = 1'b1;
                dish_sel[s] = place_dish[1];
            end
        end

        discard_sum     = {1'b0, discard_count_q} + 9'(discard[0]) + 9'(discard[1]);
        discard_count_d = (discard_sum > 9'd255) ? 8'hFF : discard_sum[7:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vsync_q         <= 1'b0;
            place_ack_q     <= '0;
            place_nack_q    <= '0;
            discard_count_q <= '0;
        end else begin
            vsync_q         <= vsync;
            place_ack_q     <= place_ack_d;
            place_nack_q    <= place_nack_d;
            discard_count_q <= discard_count_d;
        end
    end

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        serving_slot #(
            .PRESENT_FRAMES(PRESENT_FRAMES),
            .DISCARD_FRAMES(DISCARD_FRAMES)
        ) u_slot (
            .clock  (clock),
            .reset  (reset),
            .accept (accept[s]),
            .dish   (dish_sel[s]),
            .clear  (clear[s]),
            .tick   (tick),
            .run    (timer_go),
            .state  (st[s]),
            .code   (check_spaces[s]),
            .discard(discard[s])
        );
        assign slot_state[s] = st[s];
    end

    assign place_ack     = place_ack_q;
    assign place_nack    = place_nack_q;
    assign discard_count = discard_count_q;

endmodule

// File: tb/tb_serving_counter.sv
// Self-checking bench for serving_counter with short frame limits (4 present, 2 discard).
module tb_serving_counter;

    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_PRESENT = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            vsync = 1'b0;
    logic            timer_go = 1'b0;
    logic [1:0]      place_req = '0;
    logic [1:0]      place_slot = '0;
    logic [1:0][3:0] place_dish = '0;
    logic            clear_space0 = 1'b0;
    logic            clear_space1 = 1'b0;
    logic [1:0][3:0] check_spaces;
    logic [1:0]      place_ack;
    logic [1:0]      place_nack;
    logic [1:0][1:0] slot_state;
    logic [7:0]      discard_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] ack;
        logic [1:0] nack;
        logic [3:0] cs0;
        logic [3:0] cs1;
    } exp_t;

    exp_t sb[$];

    serving_counter #(
        .PRESENT_FRAMES(4),
        .DISCARD_FRAMES(2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .vsync        (vsync),
        .timer_go     (timer_go),
        .place_req    (place_req),
        .place_slot   (place_slot),
        .place_dish   (place_dish),
        .clear_space0 (clear_space0),
        .clear_space1 (clear_space1),
        .check_spaces (check_spaces),
        .place_ack    (place_ack),
        .place_nack   (place_nack),
        .slot_state   (slot_state),
        .discard_count(discard_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drives one cycle of requests/clears, then scores the registered response.
    task automatic place(input string tag, input logic [1:0] req, input logic [1:0] slot,
                         input logic [3:0] d0, input logic [3:0] d1, input logic [1:0] clr,
                         input logic [1:0] eack, input logic [1:0] enack,
                         input logic [3:0] ecs0, input logic [3:0] ecs1);
        exp_t e;
        e.tag = tag; e.ack = eack; e.nack = enack; e.cs0 = ecs0; e.cs1 = ecs1;
        sb.push_back(e);
        place_req     = req;
        place_slot    = slot;
        place_dish[0] = d0;
        place_dish[1] = d1;
        clear_space0  = clr[0];
        clear_space1  = clr[1];
        @(negedge clock);
        place_req    = '0;
        clear_space0 = 1'b0;
        clear_space1 = 1'b0;
        e = sb.pop_front();
        check({e.tag, ".ack"},  32'(place_ack),       32'(e.ack));
        check({e.tag, ".nack"}, 32'(place_nack),      32'(e.nack));
        check({e.tag, ".cs0"},  32'(check_spaces[0]), 32'(e.cs0));
        check({e.tag, ".cs1"},  32'(check_spaces[1]), 32'(e.cs1));
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            vsync = 1'b1;
            @(negedge clock);
            vsync = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".cs"},   32'(check_spaces),  32'h0);
        check({tag, ".ack"},  32'(place_ack),     32'h0);
        check({tag, ".nack"}, 32'(place_nack),    32'h0);
        check({tag, ".st"},   32'(slot_state),    32'h0);
        check({tag, ".dc"},   32'(discard_count), 32'h0);
    endtask

    initial begin
        #12;
        check_reset_outputs("reset");
        @(negedge clock);
        reset    = 1'b1;
        timer_go = 1'b1;
        @(negedge clock);

        // 1: place then claim three cycles later
        place("s1_place", 2'b01, 2'b00, 4'd4, 4'd0, 2'b00, 2'b01, 2'b00, 4'd4, 4'd0);
        check("s1_st_present", 32'(slot_state[0]), 32'(S_PRESENT));
        @(negedge clock);
        check("s1_ack_pulse", 32'(place_ack), 32'h0);
        @(negedge clock);
        place("s1_clear", 2'b00, 2'b00, 4'd0, 4'd0, 2'b01, 2'b00, 2'b00, 4'd0, 4'd0);
        check("s1_st_empty", 32'(slot_state[0]), 32'(S_EMPTY));
        check("s1_dc", 32'(discard_count), 32'd0);

        // 2: unclaimed dish times out and discards
        place("s2_place", 2'b01, 2'b01, 4'd5, 4'd0, 2'b00, 2'b01, 2'b00, 4'd0, 4'd5);
        tick_n(3);
        check("s2_st_3ticks", 32'(slot_state[1]), 32'(S_PRESENT));
        check("s2_cs_3ticks", 32'(check_spaces[1]), 32'd5);
        tick_n(1);
        check("s2_st_discard", 32'(slot_state[1]), 32'(S_DISCARD));
        check("s2_cs_discard", 32'(check_spaces[1]), 32'd0);
        check("s2_dc", 32'(discard_count), 32'd1);
        tick_n(1);
        check("s2_st_disc1", 32'(slot_state[1]), 32'(S_DISCARD));
        tick_n(1);
        check("s2_st_empty", 32'(slot_state[1]), 32'(S_EMPTY));
        check("s2_dc_hold", 32'(discard_count), 32'd1);

        // 3: arbitration and acceptance corners
        place("s3_contest", 2'b11, 2'b00, 4'd2, 4'd3, 2'b00, 2'b01, 2'b10, 4'd2, 4'd0);
        place("s3_clr0", 2'b00, 2'b00, 4'd0, 4'd0, 2'b01, 2'b00, 2'b00, 4'd0, 4'd0);
        place("s3_split", 2'b11, 2'b10, 4'd1, 4'd6, 2'b00, 2'b11, 2'b00, 4'd1, 4'd6);
        place("s3_clr_both", 2'b00, 2'b00, 4'd0, 4'd0, 2'b11, 2'b00, 2'b00, 4'd0, 4'd0);
        place("s3_dish0", 2'b01, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 2'b01, 4'd0, 4'd0);
        place("s3_p0_8", 2'b01, 2'b00, 4'd8, 4'd0, 2'b00, 2'b01, 2'b00, 4'd8, 4'd0);
        place("s3_busy", 2'b10, 2'b00, 4'd0, 4'd9, 2'b00, 2'b00, 2'b10, 4'd8, 4'd0);
        place("s3_clr_race", 2'b10, 2'b00, 4'd0, 4'd9, 2'b01, 2'b00, 2'b10, 4'd0, 4'd0);
        check("s3_st_empty", 32'(slot_state[0]), 32'(S_EMPTY));

        // 4: timer_go low nacks requests and freezes frame counters
        timer_go = 1'b0;
        place("s4_stopped", 2'b01, 2'b00, 4'd3, 4'd0, 2'b00, 2'b00, 2'b01, 4'd0, 4'd0);
        timer_go = 1'b1;
        place("s4_place", 2'b01, 2'b00, 4'd3, 4'd0, 2'b00, 2'b01, 2'b00, 4'd3, 4'd0);
        tick_n(1);
        timer_go = 1'b0;
        tick_n(10);
        check("s4_frozen_st", 32'(slot_state[0]), 32'(S_PRESENT));
        check("s4_frozen_dc", 32'(discard_count), 32'd1);
        timer_go = 1'b1;
        tick_n(2);
        check("s4_st_remain", 32'(slot_state[0]), 32'(S_PRESENT));
        tick_n(1);
        check("s4_st_discard", 32'(slot_state[0]), 32'(S_DISCARD));
        check("s4_dc", 32'(discard_count), 32'd2);
        tick_n(2);
        check("s4_st_empty", 32'(slot_state[0]), 32'(S_EMPTY));

        // 5: clear coincides with the timeout tick
        place("s5_place", 2'b01, 2'b00, 4'd6, 4'd0, 2'b00, 2'b01, 2'b00, 4'd6, 4'd0);
        tick_n(3);
        vsync        = 1'b1;
        clear_space0 = 1'b1;
        @(negedge clock);
        vsync        = 1'b0;
        clear_space0 = 1'b0;
        check("s5_st", 32'(slot_state[0]), 32'(S_EMPTY));
        check("s5_cs", 32'(check_spaces[0]), 32'd0);
        check("s5_dc", 32'(discard_count), 32'd2);
        @(negedge clock);

        // 6: asynchronous reset mid-presentation
        place("s6_place", 2'b01, 2'b00, 4'd7, 4'd0, 2'b00, 2'b01, 2'b00, 4'd7, 4'd0);
        #2 reset = 1'b0;
        #1 check_reset_outputs("s6_async");
        @(negedge clock);
        reset = 1'b1;
        tick_n(5);
        check("s6_dc_stays", 32'(discard_count), 32'd0);
        check("s6_st_empty", 32'(slot_state[0]), 32'(S_EMPTY));
        place("s6_dish0", 2'b01, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 2'b01, 4'd0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
